uart_txq: RTL and testbench
===========================

UART_TXQ -- requirements
Module: uart_txq

Interface
REQ-001 The block SHALL provide parameter DEPTH_LOG2, default 3, log2 of the FIFO depth (8 entries).
REQ-002 The block SHALL provide port sys_clk  input  1  system clock; all state updates on its rising edge.
REQ-003 The block SHALL provide port sys_rst_l  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL provide port wr_en_i  input  1  host write strobe, one byte per cycle.
REQ-005 The block SHALL provide port wr_data_i  input  8  host byte.
REQ-006 The block SHALL provide port flush_i  input  1  synchronous FIFO clear.
REQ-007 The block SHALL provide port full_o  output  1  FIFO holds 2^DEPTH_LOG2 entries.
REQ-008 The block SHALL provide port empty_o  output  1  FIFO holds 0 entries.
REQ-009 The block SHALL provide port level_o  output  DEPTH_LOG2+1  current entry count.
REQ-010 The block SHALL provide port xmitH  output  1  registered one-cycle launch pulse to the UART transmitter.
REQ-011 The block SHALL provide port xmit_dataH  output  8  registered byte to the transmitter.
REQ-012 The block SHALL provide port xmit_doneH  input  1  transmitter idle/done, high while idle, low while sending.
REQ-013 The block SHALL provide port overflow_o  output  1  sticky write-while-full flag.

Function
REQ-014 The FIFO SHALL use circular read/write pointers of DEPTH_LOG2 bits; pointers SHALL wrap from 2^DEPTH_LOG2-1 to 0.
REQ-015 A write (wr_en_i=1, not full, flush_i=0) SHALL store wr_data_i and increment level_o at the same edge.
REQ-016 A write while full SHALL be dropped; FIFO contents and level_o SHALL be unchanged.
REQ-017 A simultaneous write and pop SHALL both occur; level_o SHALL be unchanged; this SHALL also hold when full (pop frees the slot).
REQ-018 Launch FSM states SHALL be IDLE, LAUNCH, WAIT_LOW, WAIT_HIGH.
REQ-019 IDLE: if FIFO non-empty and xmit_doneH=1 -> pop head into xmit_dataH, go LAUNCH; otherwise stay.
REQ-020 LAUNCH: xmitH=1 for exactly this one cycle; unconditionally go WAIT_LOW.
REQ-021 WAIT_LOW: stay until xmit_doneH=0, then go WAIT_HIGH.
REQ-022 WAIT_HIGH: stay until xmit_doneH=1, then go IDLE.
REQ-023 xmitH SHALL be 0 in every state other than LAUNCH.
REQ-024 xmit_dataH SHALL hold its value from LAUNCH until the next pop.
REQ-025 Latency: a write sampled at edge N into an empty FIFO with the transmitter idle SHALL produce xmitH=1 during the cycle after edge N+1.
REQ-026 flush_i SHALL zero both pointers and level_o at the next edge; a write in the same cycle SHALL be discarded and SHALL NOT set overflow_o.
REQ-027 flush_i SHALL NOT abort a byte already launched; the FSM SHALL complete its WAIT_LOW/WAIT_HIGH sequence.
REQ-028 Pop in IDLE and flush_i in the same cycle: flush SHALL win, no pop, FSM stays IDLE.

Reset
REQ-029 On sys_rst_l=0, the block SHALL immediately force: FSM IDLE, pointers 0, level_o=0, empty_o=1, full_o=0, xmitH=0, xmit_dataH=8'h00, overflow_o=0.
REQ-030 Reset mid-transfer SHALL abandon the in-flight byte and all queued bytes.

Configuration
REQ-031 Macro UART_TXQ_OVERFLOW_EN, when defined, SHALL make overflow_o set on any dropped write per REQ-016 and clear only on flush_i or reset.
REQ-032 With UART_TXQ_OVERFLOW_EN undefined, overflow_o SHALL be constant 0; all other behaviour SHALL be identical.

Verification
REQ-033 Write 8'hA5 at edge N, transmitter idle -> xmitH=1 for exactly one cycle after edge N+1 with xmit_dataH=8'hA5.
REQ-034 Write 9 bytes 8'h01..8'h09 back-to-back with xmit_doneH held 0 -> level_o=8, full_o=1, 8'h09 dropped, overflow_o=1 (macro on) / 0 (macro off).
REQ-035 Queue 8'h10, 8'h20, 8'h30; transmitter model drops xmit_doneH 2 cycles after each xmitH and raises it 160 cycles later -> three launches in order, none until xmit_doneH returns high.
REQ-036 FIFO full, simultaneous write 8'h77 and pop -> level_o stays 8, 8'h77 emitted last, overflow_o unchanged.
REQ-037 Flush with 4 queued bytes during WAIT_LOW -> level_o=0, empty_o=1, in-flight byte completes, no further xmitH.
REQ-038 Assert sys_rst_l=0 during WAIT_HIGH with 3 queued -> all outputs at reset values immediately; no xmitH after release until a new write.

Source files
------------

// File: rtl/uart_txq_if.sv
// rtl/uart_txq_if.sv - host/transmitter signal bundle for the uart_txq byte queue
interface uart_txq_if #(
    parameter int DEPTH_LOG2 = 3
);
    logic                  wr_en_i;
    logic [7:0]            wr_data_i;
    logic                  flush_i;
    logic                  full_o;
    logic                  empty_o;
    logic [DEPTH_LOG2:0]   level_o;
    logic                  xmitH;
    logic [7:0]            xmit_dataH;
    logic                  xmit_doneH;
    logic                  overflow_o;

    modport master (
        output wr_en_i, wr_data_i, flush_i, xmit_doneH,
        input  full_o, empty_o, level_o, xmitH, xmit_dataH, overflow_o
    );

    modport slave (
        input  wr_en_i, wr_data_i, flush_i, xmit_doneH,
        output full_o, empty_o, level_o, xmitH, xmit_dataH, overflow_o
    );
endinterface

// File: rtl/uart_txq.sv
// rtl/uart_txq.sv - byte FIFO feeding a UART transmitter through a one-pulse launch handshake
// Optional sticky overflow flag enabled by defining UART_TXQ_OVERFLOW_EN.
module uart_txq #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic     sys_clk,
    input  logic     sys_rst_l,
    uart_txq_if.slave txq
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_LOW, WAIT_HIGH} state_t;

    state_t                  state;
    logic [7:0]              mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wrPtr;
    logic [DEPTH_LOG2-1:0]   rdPtr;
    logic [DEPTH_LOG2:0]     level;
    logic                    full;
    logic                    empty;
    logic                    pop;
    logic                    push;
    logic                    xmitReg;
    logic [7:0]              xmitData;

    assign full  = (level == FULL_LEVEL);
    assign empty = (level == '0);

    // Flush beats a pending pop; a pop in the same cycle frees room for a write into a full FIFO.
    assign pop  = (state == IDLE) && !empty && txq.xmit_doneH && !txq.flush_i;
    assign push = txq.wr_en_i && !txq.flush_i && (!full || pop);

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else if (txq.flush_i) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + (DEPTH_LOG2)'(1);
            if (pop)  rdPtr <= rdPtr + (DEPTH_LOG2)'(1);
            case ({push, pop})
                2'b10:   level <= level + (DEPTH_LOG2+1)'(1);
                2'b01:   level <= level - (DEPTH_LOG2+1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) mem[wrPtr] <= txq.wr_data_i;
    end

    // Launch sequencer: a popped byte must see the transmitter go busy and then idle again
    // before the next byte may be launched.
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            state    <= IDLE;
            xmitReg  <= 1'b0;
            xmitData <= 8'h00;
        end else begin
            xmitReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        xmitData <= mem[rdPtr];
                        xmitReg  <= 1'b1;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH:    state <= WAIT_LOW;
                WAIT_LOW:  if (!txq.xmit_doneH) state <= WAIT_HIGH;
                WAIT_HIGH: if (txq.xmit_doneH)  state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

`ifdef UART_TXQ_OVERFLOW_EN
    logic drop;
    logic overflow;

    assign drop = txq.wr_en_i && !txq.flush_i && full && !pop;

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l)        overflow <= 1'b0;
        else if (txq.flush_i)  overflow <= 1'b0;
        else if (drop)         overflow <= 1'b1;
    end

    assign txq.overflow_o = overflow;
`else
    assign txq.overflow_o = 1'b0;
`endif

    assign txq.full_o     = full;
    assign txq.empty_o    = empty;
    assign txq.level_o    = level;
    assign txq.xmitH      = xmitReg;
    assign txq.xmit_dataH = xmitData;
endmodule

// File: tb/tb_uart_txq.sv
// tb/tb_uart_txq.sv - table vectors, directed corner sequences and a queue-model scoreboard for uart_txq
module tb_uart_txq;
    localparam int DL    = 3;
    localparam int DEPTH = 8;
`ifdef UART_TXQ_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic sys_clk   = 1'b0;
    logic sys_rst_l = 1'b0;

    uart_txq_if #(.DEPTH_LOG2(DL)) bus ();

    uart_txq #(.DEPTH_LOG2(DL)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_l (sys_rst_l),
        .txq       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int nChecks = 0;
    int nFail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic       fl;
        logic       done;
        logic [3:0] lvl;
        logic       emp;
        logic       xm;
        logic [7:0] xd;
    } vec_t;

    function automatic vec_t mk(logic wr, logic [7:0] d, logic fl, logic done,
                                logic [3:0] lvl, logic emp, logic xm, logic [7:0] xd);
        vec_t v;
        v.wr = wr; v.d = d; v.fl = fl; v.done = done;
        v.lvl = lvl; v.emp = emp; v.xm = xm; v.xd = xd;
        return v;
    endfunction

    // Reference model: byte queue, sticky overflow, launch permission and a transmitter stand-in.
    logic [7:0] q[$];
    logic [7:0] emitted[$];
    int         launchCyc[$];
    bit         mOvf;
    bit         launchOk;
    bit         sawLow;
    bit         forceLow;
    int         dropIn;
    int         lowLeft;
    int         txDelay;
    int         txBusy;
    int         cyc;

    task automatic modelClear();
        q.delete();
        mOvf     = 1'b0;
        launchOk = 1'b1;
        sawLow   = 1'b0;
        forceLow = 1'b0;
        dropIn   = 0;
        lowLeft  = 0;
    endtask

    task automatic doReset();
        sys_rst_l      = 1'b0;
        bus.wr_en_i    = 1'b0;
        bus.wr_data_i  = 8'h00;
        bus.flush_i    = 1'b0;
        bus.xmit_doneH = 1'b1;
        modelClear();
        @(posedge sys_clk);
        #1;
        sys_rst_l = 1'b1;
    endtask

    task automatic step();
        logic       doneAtEdge;
        bit         expLaunch;
        logic [7:0] expByte;
        if (forceLow) begin
            bus.xmit_doneH = 1'b0;
        end else if (dropIn > 0) begin
            dropIn--;
            if (dropIn == 0) begin
                bus.xmit_doneH = 1'b0;
                lowLeft = txBusy;
            end
        end else if (lowLeft > 0) begin
            lowLeft--;
            if (lowLeft == 0) bus.xmit_doneH = 1'b1;
        end
        doneAtEdge = bus.xmit_doneH;
        expLaunch  = launchOk && doneAtEdge && (q.size() > 0) && !bus.flush_i;
        @(posedge sys_clk);
        #1;
        cyc++;
        chk("xmitH", 32'(bus.xmitH), 32'(expLaunch));
        if (expLaunch) begin
            expByte = q.pop_front();
            chk("xmit_dataH", 32'(bus.xmit_dataH), 32'(expByte));
            emitted.push_back(bus.xmit_dataH);
            launchCyc.push_back(cyc);
            launchOk = 1'b0;
            sawLow   = 1'b0;
            dropIn   = txDelay;
        end else if (!launchOk) begin
            if (!doneAtEdge)  sawLow   = 1'b1;
            else if (sawLow)  launchOk = 1'b1;
        end
        if (bus.flush_i) begin
            q.delete();
            mOvf = 1'b0;
        end else if (bus.wr_en_i) begin
            if (q.size() < DEPTH) q.push_back(bus.wr_data_i);
            else if (OVF_EN)      mOvf = 1'b1;
        end
        chk("level_o",    32'(bus.level_o),    32'(q.size()));
        chk("empty_o",    32'(bus.empty_o),    32'(q.size() == 0));
        chk("full_o",     32'(bus.full_o),     32'(q.size() == DEPTH));
        chk("overflow_o", 32'(bus.overflow_o), 32'(mOvf));
    endtask

    task automatic wrStep(input logic [7:0] d);
        bus.wr_en_i   = 1'b1;
        bus.wr_data_i = d;
        step();
        bus.wr_en_i   = 1'b0;
    endtask

    vec_t tbl[13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0; txDelay = 2; txBusy = 3;
        bus.wr_en_i = 1'b0; bus.wr_data_i = 8'h00; bus.flush_i = 1'b0; bus.xmit_doneH = 1'b1;
        modelClear();

        tbl[0]  = mk(1'b1, 8'hA5, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 8'h00);
        tbl[1]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 8'hA5);
        tbl[2]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 8'hA5);
        tbl[3]  = mk(1'b1, 8'h11, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 8'hA5);
        tbl[4]  = mk(1'b1, 8'h22, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 8'hA5);
        tbl[5]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 8'hA5);
        tbl[6]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 8'h11);
        tbl[7]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 8'h11);
        tbl[8]  = mk(1'b1, 8'h33, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 8'h11);
        tbl[9]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 8'h11);
        tbl[10] = mk(1'b1, 8'h44, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 8'h11);
        tbl[11] = mk(1'b0, 8'h00, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 8'h11);
        tbl[12] = mk(1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 8'h11);

        // Reset values while reset is held
        @(posedge sys_clk);
        #1;
        chk("rst_level",  32'(bus.level_o),    32'd0);
        chk("rst_empty",  32'(bus.empty_o),    32'd1);
        chk("rst_full",   32'(bus.full_o),     32'd0);
        chk("rst_xmitH",  32'(bus.xmitH),      32'd0);
        chk("rst_xdata",  32'(bus.xmit_dataH), 32'h00);
        chk("rst_ovf",    32'(bus.overflow_o), 32'd0);
        sys_rst_l = 1'b1;

        for (int i = 0; i < 13; i++) begin
            bus.wr_en_i    = tbl[i].wr;
            bus.wr_data_i  = tbl[i].d;
            bus.flush_i    = tbl[i].fl;
            bus.xmit_doneH = tbl[i].done;
            @(posedge sys_clk);
            #1;
            chk($sformatf("tbl%0d_level", i), 32'(bus.level_o),    32'(tbl[i].lvl));
            chk($sformatf("tbl%0d_empty", i), 32'(bus.empty_o),    32'(tbl[i].emp));
            chk($sformatf("tbl%0d_full",  i), 32'(bus.full_o),     32'd0);
            chk($sformatf("tbl%0d_xmitH", i), 32'(bus.xmitH),      32'(tbl[i].xm));
            chk($sformatf("tbl%0d_xdata", i), 32'(bus.xmit_dataH), 32'(tbl[i].xd));
            chk($sformatf("tbl%0d_ovf",   i), 32'(bus.overflow_o), 32'd0);
        end
        bus.wr_en_i = 1'b0; bus.flush_i = 1'b0;

        // Overfill with the transmitter busy, then write while full with a simultaneous pop
        doReset();
        emitted.delete();
        forceLow = 1'b1;
        for (int i = 1; i <= 9; i++) wrStep(8'(i));
        chk("fill_level", 32'(bus.level_o),    32'd8);
        chk("fill_full",  32'(bus.full_o),     32'd1);
        chk("fill_ovf",   32'(bus.overflow_o), 32'(OVF_EN));
        forceLow = 1'b0;
        bus.xmit_doneH = 1'b1;
        wrStep(8'h77);
        chk("wp_level", 32'(bus.level_o),    32'd8);
        chk("wp_ovf",   32'(bus.overflow_o), 32'(OVF_EN));
        for (int c = 0; c < 400 && emitted.size() < 9; c++) step();
        chk("fill_drain_count", 32'(emitted.size()), 32'd9);
        for (int i = 0; i < 9 && i < emitted.size(); i++)
            chk($sformatf("fill_order%0d", i), 32'(emitted[i]), (i < 8) ? 32'(i + 1) : 32'h77);

        // Long transmitter busy time: launches strictly follow the done handshake
        doReset();
        emitted.delete(); launchCyc.delete();
        txDelay = 2; txBusy = 160;
        wrStep(8'h10); wrStep(8'h20); wrStep(8'h30);
        for (int c = 0; c < 1000 && !(emitted.size() == 3 && lowLeft == 0); c++) step();
        chk("slow_count", 32'(emitted.size()), 32'd3);
        if (emitted.size() == 3) begin
            chk("slow_b0", 32'(emitted[0]), 32'h10);
            chk("slow_b1", 32'(emitted[1]), 32'h20);
            chk("slow_b2", 32'(emitted[2]), 32'h30);
            chk("slow_gap1", 32'(launchCyc[1] - launchCyc[0] >= 160), 32'd1);
            chk("slow_gap2", 32'(launchCyc[2] - launchCyc[1] >= 160), 32'd1);
        end

        // Flush while the launched byte is still in WAIT_LOW
        doReset();
        emitted.delete();
        txDelay = 4; txBusy = 6;
        for (int i = 0; i < 5; i++) wrStep(8'hC0 + 8'(i));
        chk("fl_pre_level", 32'(bus.level_o), 32'd4);
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        chk("fl_level", 32'(bus.level_o), 32'd0);
        chk("fl_empty", 32'(bus.empty_o), 32'd1);
        for (int c = 0; c < 30; c++) step();
        chk("fl_launches", 32'(emitted.size()), 32'd1);
        wrStep(8'h5A);
        for (int c = 0; c < 30 && emitted.size() < 2; c++) step();
        chk("fl_after_count", 32'(emitted.size()), 32'd2);

        // Asynchronous reset during WAIT_HIGH with three bytes queued
        doReset();
        emitted.delete();
        txDelay = 2; txBusy = 10;
        for (int i = 0; i < 4; i++) wrStep(8'hE0 + 8'(i));
        chk("rs_pre_level", 32'(bus.level_o), 32'd3);
        #2;
        sys_rst_l = 1'b0;
        #1;
        chk("rs_level", 32'(bus.level_o),    32'd0);
        chk("rs_empty", 32'(bus.empty_o),    32'd1);
        chk("rs_full",  32'(bus.full_o),     32'd0);
        chk("rs_xmitH", 32'(bus.xmitH),      32'd0);
        chk("rs_xdata", 32'(bus.xmit_dataH), 32'h00);
        chk("rs_ovf",   32'(bus.overflow_o), 32'd0);
        doReset();
        emitted.delete();
        for (int c = 0; c < 20; c++) step();
        chk("rs_quiet", 32'(emitted.size()), 32'd0);

        // Randomized traffic against the queue model
        doReset();
        for (int c = 0; c < 3000; c++) begin
            txDelay       = int'($urandom_range(4, 2));
            txBusy        = int'($urandom_range(6, 1));
            bus.wr_en_i   = ($urandom_range(99) < 60);
            bus.wr_data_i = 8'($urandom);
            bus.flush_i   = ($urandom_range(99) < 3);
            step();
        end
        bus.wr_en_i = 1'b0; bus.flush_i = 1'b0;
        for (int c = 0; c < 200 && q.size() > 0; c++) step();
        chk("rand_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
